// File: rtl/tt_resp_pkg.sv
// Shared opcodes, FSM state encoding and pad constants
// for the host pin-protocol responder.
package tt_resp_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_ACK_HI = 2'd2
    } state_t;

    localparam logic [7:0] UIO_OE_MASK = 8'b0000_0110;

endpackage

// File: rtl/tt_req_sync.sv
// Multi-flop synchronizer bringing the asynchronous host req
// into the clk domain.
module tt_req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic req_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tt_pin_responder.sv
// Device-side responder: executes host command bytes against a
// small register file and answers with a four-phase req/ack.
module tt_pin_responder
    import tt_resp_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         REG_AW      = 2,
    parameter logic [7:0] DEV_ID      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NREG = 1 << REG_AW;

    logic req_s;

    state_t              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          uo_q, uo_d;
    logic                ack_q, ack_d;
    logic                pend_q, pend_d;
    logic [REG_AW-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]          regs_q [NREG];
    logic [7:0]          regs_d [NREG];

    logic [1:0]          op;
    logic [REG_AW-1:0]   addr;
    logic                unused_bits;

    tt_req_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .req  (uio_in[0]),
        .req_s(req_s)
    );

    assign op          = cmd_q[7:6];
    assign addr        = cmd_q[REG_AW-1:0];
    assign unused_bits = ^{uio_in[7:1], cmd_q[5:REG_AW]};

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        uo_d        = uo_q;
        ack_d       = ack_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        regs_d      = regs_q;
        // Abort drops the transaction before any register commit.
        if (!ena) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_d = 1'b0;
                    if (req_s) begin
                        cmd_d   = ui_in;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK_HI;
                    if (pend_q) begin
                        regs_d[pend_addr_q] = cmd_q;
                        uo_d                = cmd_q;
                        pend_d              = 1'b0;
                    end else begin
                        case (op)
                            OP_NOP: uo_d = DEV_ID;
                            OP_WRITE: begin
                                uo_d        = 8'h00;
                                pend_d      = 1'b1;
                                pend_addr_d = addr;
                            end
                            OP_READ: uo_d = regs_q[addr];
                            default: begin
                                regs_d[addr] = regs_q[addr] + 8'd1;
                                uo_d         = regs_q[addr] + 8'd1;
                            end
                        endcase
                    end
                end
                ST_ACK_HI: begin
                    if (!req_s) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            uo_q        <= 8'h00;
            ack_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            uo_q        <= uo_d;
            ack_q       <= ack_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {5'b0, state_q != ST_IDLE, ack_q, 1'b0};
    assign uio_oe  = UIO_OE_MASK;

endmodule
